// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-based modulo counter: direction encoding and
// the terminal-count helper.
package jk_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Largest legal count for a given modulus.
  function automatic int unsigned max_count(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

// File: rtl/jk_cell_rn.sv
// Single JK flip-flop with asynchronous active-low clear (q=0, qbar=1).
module jk_cell_rn (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b00:   q_d = q_q;
      2'b01:   q_d = 1'b0;
      2'b10:   q_d = 1'b1;
      2'b11:   q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose storage is a row of JK cells; J/K per
// bit come from the computed next state via JK excitation.
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : gen_bad_modulus
    $error("jk_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(max_count(MODULUS));

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             wrap_d, wrap_q;
  logic             load_err_d, load_err_q;

  always_comb begin
    nxt        = q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_val <= MaxCnt) begin
        nxt = load_val;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up == DIR_UP) begin
        if (q == MaxCnt) begin
          nxt    = '0;
          wrap_d = 1'b1;
        end else if (q > MaxCnt) begin
          // Unreachable state: recover to zero.
          nxt = '0;
        end else begin
          nxt = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          nxt    = MaxCnt;
          wrap_d = 1'b1;
        end else if (q > MaxCnt) begin
          nxt = '0;
        end else begin
          nxt = q - 1'b1;
        end
      end
    end
  end

  // Excitation: set on 0->1, clear on 1->0, otherwise J=K=0.
  assign j = nxt & ~q;
  assign k = ~nxt & q;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_cells
    jk_cell_rn u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .j    (j[i]),
      .k    (k[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  assign tc = en & ~load & (((up == DIR_UP) & (q == MaxCnt)) | ((up == DIR_DOWN) & (q == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed scenarios followed by
// random stimulus, all compared against an arithmetic reference model.
module tb_jk_mod_counter;

  localparam int unsigned Width = 4;
  localparam int unsigned Mod   = 10;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up;
  logic             load;
  logic [Width-1:0] load_val;
  logic [Width-1:0] q;
  logic [Width-1:0] qbar;
  logic             tc;
  logic             wrap;
  logic             load_err;

  int n_checks;
  int n_fail;

  // Reference model state.
  int m_cnt;
  int m_wrap;
  int m_err;

  jk_mod_counter #(
    .WIDTH  (Width),
    .MODULUS(Mod)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .up      (up),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .qbar    (qbar),
    .tc      (tc),
    .wrap    (wrap),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".q"}, int'(q), m_cnt);
    check_eq({tag, ".qbar"}, int'(qbar), (~m_cnt) & ((1 << Width) - 1));
    check_eq({tag, ".wrap"}, int'(wrap), m_wrap);
    check_eq({tag, ".load_err"}, int'(load_err), m_err);
  endtask

  // Apply one set of inputs for one clock and check before and after the edge.
  task automatic cycle(input string tag, input logic i_en, input logic i_up, input logic i_load,
                       input int i_val);
    int exp_tc;
    @(negedge clk);
    en       = i_en;
    up       = i_up;
    load     = i_load;
    load_val = Width'(i_val);
    #1;
    exp_tc = (i_en && !i_load &&
              ((i_up && m_cnt == Mod - 1) || (!i_up && m_cnt == 0))) ? 1 : 0;
    check_eq({tag, ".tc"}, int'(tc), exp_tc);
    @(posedge clk);
    m_wrap = 0;
    m_err  = 0;
    if (i_load) begin
      if (i_val < Mod) m_cnt = i_val;
      else m_err = 1;
    end else if (i_en) begin
      if (i_up) begin
        m_wrap = (m_cnt == Mod - 1) ? 1 : 0;
        m_cnt  = (m_cnt + 1) % Mod;
      end else begin
        m_wrap = (m_cnt == 0) ? 1 : 0;
        m_cnt  = (m_cnt + Mod - 1) % Mod;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_cnt    = 0;
    m_wrap   = 0;
    m_err    = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;

    #2;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Count up through a wrap.
    for (int i = 0; i < 12; i++) cycle("up_run", 1'b1, 1'b1, 1'b0, 0);

    // Load then count down through a wrap.
    cycle("load3", 1'b0, 1'b0, 1'b1, 3);
    for (int i = 0; i < 5; i++) cycle("down_run", 1'b1, 1'b0, 1'b0, 0);

    // Out-of-range load is rejected.
    cycle("load5", 1'b0, 1'b1, 1'b1, 5);
    cycle("bad_load", 1'b1, 1'b1, 1'b1, 12);
    cycle("after_bad", 1'b0, 1'b1, 1'b0, 0);
    check_eq("bad_load.hold", int'(q), 5);

    // Load wins over count enable.
    cycle("load2", 1'b0, 1'b1, 1'b1, 2);
    cycle("load_prio", 1'b1, 1'b1, 1'b1, 7);
    check_eq("load_prio.q", int'(q), 7);

    // Asynchronous reset mid-count.
    cycle("load5b", 1'b0, 1'b1, 1'b1, 5);
    cycle("to6", 1'b1, 1'b1, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_cnt  = 0;
    m_wrap = 0;
    m_err  = 0;
    check_outputs("async_rst");
    en   = 1'b0;
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("resume", 1'b1, 1'b1, 1'b0, 0);

    // Hold with en low while other inputs wiggle.
    cycle("load4", 1'b0, 1'b1, 1'b1, 4);
    for (int i = 0; i < 5; i++) begin
      cycle("hold", 1'b0, 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 15)));
    end

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter built from a row of JK flip-flop cells.
- Each bit is one JK cell. Per-bit J/K drive is derived from next-state logic using JK excitation.
- Sits directly downstream of the team's JK flip-flop stage: it consumes JK cells as its storage elements.
- Produces a count, its complement, and cascade and status flags for the sequencing/display logic that follows.

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 10: count range is 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load request.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count.
- qbar  out  WIDTH  bitwise complement of q; always equal to ~q.
- tc  out  1  terminal count, combinational, for cascading.
- wrap  out  1  registered one-cycle pulse, asserted the cycle after a wrap.
- load_err  out  1  registered one-cycle pulse, asserted the cycle after a rejected load.

Behaviour:
- Reset:
  - rst_n low clears immediately, without waiting for clk.
  - Reset values: q=0, qbar=all ones, wrap=0, load_err=0.
  - Reset asserted mid-count or mid-load discards the in-flight operation.
  - First active edge is the first rising clk with rst_n high.
- Priority per rising edge: load > en > hold.
- load=1 with load_val < MODULUS:
  - q <= load_val.
  - wrap=0, load_err=0 next cycle.
  - en is ignored that cycle.
- load=1 with load_val >= MODULUS:
  - q holds.
  - load_err=1 for exactly one cycle.
  - en is ignored that cycle.
- load=0, en=1, up=1:
  - q <= q+1.
  - If q==MODULUS-1, q <= 0 and wrap=1 next cycle.
- load=0, en=1, up=0:
  - q <= q-1.
  - If q==0, q <= MODULUS-1 and wrap=1 next cycle.
- load=0, en=0: q holds. All JK cells get J=K=0; no cell sees J=K=1 except when it must toggle.
- Excitation per bit i, where nxt is the computed next state:
  - J_i = nxt_i & ~q_i.
  - K_i = ~nxt_i & q_i.
  - Never J=K=1 except on a toggle.
- tc:
  - tc = en & ~load & ((up & q==MODULUS-1) | (~up & q==0)).
  - Purely combinational; no registered delay. Lets a following stage enable on the same edge.
- Direction change: up changing between cycles takes effect on the next edge. There is no pipeline, so latency is 1 clk for every operation.
- Arithmetic:
  - All compares use unsigned WIDTH-bit arithmetic.
  - MODULUS-1 is a WIDTH-bit constant.
  - Unused states (q >= MODULUS) are unreachable. Defensively, if reached while counting they return to 0 on the next enabled edge.
- Power of two (MODULUS == 2**WIDTH): the counter wraps naturally, and load_err can never assert.

Decomposition:
- Shared package/header jk_counter_pkg:
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - Helper constant function for the max count (MODULUS-1).
- Sub-module jk_cell_rn: a single JK flip-flop.
  - Ports: clk, rst_n, j, k, q, qbar.
  - Asynchronous active-low clear to q=0/qbar=1.
  - Behaviour: hold, reset, set, toggle.
  - Instantiated WIDTH times via generate.
- The top module holds the next-state logic, excitation, tc and the wrap/load_err registers.

Test Plan (WIDTH=4, MODULUS=10):
1. Reset, then en=1, up=1 for 12 cycles -> q = 1..9,0,1,2. wrap high only in the cycle after 9->0. tc high while q==9. qbar==~q every cycle.
2. load=1, load_val=3, then en=1, up=0 for 5 cycles -> q=3,2,1,0,9,8. wrap pulses once after 0->9. tc high while q==0.
3. load=1, load_val=12 while q=5 -> q stays 5. load_err=1 for exactly one cycle, then 0.
4. load=1, load_val=7 together with en=1, up=1 at q=2 -> q=7, not 3. No wrap.
5. Counting at q=6, drop rst_n between clock edges -> q=0 and qbar=4'b1111 immediately, before the next clk edge. wrap=0. Count resumes from 0 after release.
6. en=0 for 5 cycles at q=4, toggling up and load_val -> q stays 4. tc=0, wrap=0, load_err=0.
